fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch and prefetch stage for the MIPS-lite core. Issues word requests to instruction memory over a req/ack handshake, buffers returned words with their PCs in a small FIFO, and presents the head instruction, its opcode field, and a stall flag to the main decode controller. It also accepts branch and jump redirects from execute, flushes the wrong-path words, and squashes any fetch already in flight.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, fetch address after reset; must be word aligned.
- DEPTH, 4, prefetch FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request; registered.
- imem_addr  output  32  fetch word address; registered, bits [1:0] always 0.
- imem_ack  input  1  response strobe; imem_rdata is valid in the same cycle.
- imem_rdata  input  32  fetched instruction word.
- redirect  input  1  taken branch or jump; one-cycle pulse.
- redirect_pc  input  32  target address; sampled only when redirect=1.
- hold  input  1  downstream back-pressure, for example a load-use bubble; the head entry is not consumed.
- instr  output  32  head instruction; 32'h0 when instr_valid=0.
- op  output  6  always equal to instr[31:26].
- pc_out  output  32  PC of the head instruction; 0 when instr_valid=0.
- instr_valid  output  1  FIFO non-empty.
- stall  output  1  always equal to !instr_valid; drives the controller's stall input.

## Operation
- Fetch FSM states:
  - FETCH: normal issue.
  - SQUASH: a redirect landed while a request was outstanding; wait for that ack and discard its data.
- FIFO holds {pc, word} pairs.
  - count = number of occupied entries.
  - out = 1 while imem_req=1, 0 otherwise.
- Issue condition in FETCH: imem_req=0, no redirect, and count + out < DEPTH.
  - When met: next cycle imem_req=1 and imem_addr=fetch_pc.
- Request stability: once imem_req=1, it and imem_addr stay unchanged until the cycle imem_ack=1.
  - This holds through redirects; the SQUASH state keeps the stale request alive.
- Ack in FETCH:
  - Push {imem_addr, imem_rdata}.
  - fetch_pc <= imem_addr + 4, wrapping modulo 2^32.
  - imem_req falls unless the issue condition still holds. If it holds, imem_req stays 1 and imem_addr <= imem_addr + 4, giving back-to-back fetch.
- Ack in SQUASH: drop the data, return to FETCH, and start issuing at the redirect target.
- Consume: when instr_valid=1 and hold=0 and redirect=0, the head pops at the edge.
- Redirect takes priority over every other event in the same cycle:
  - The FIFO empties at the edge, so instr_valid=0 next cycle.
  - fetch_pc <= redirect_pc.
  - If imem_req=1 and imem_ack=0: go to SQUASH.
  - If imem_req=1 and imem_ack=1: drop the acked word, clear imem_req, stay in FETCH.
  - If imem_req=0: stay in FETCH.
- A second redirect during SQUASH updates fetch_pc only; the state stays SQUASH.
- Push and pop in the same cycle are legal when full or empty:
  - Full: the push is allowed because the issue condition already reserved the slot.
  - Empty: a pushed word is not visible until the next cycle (no bypass).

## Timing
- Reset values:
  - imem_req=0, imem_addr=0.
  - fetch_pc=RESET_PC, count=0, state=FETCH.
  - instr=0, op=0, pc_out=0, instr_valid=0, stall=1.
- First request: imem_req=1 with imem_addr=RESET_PC in the first cycle after the first clock edge with rst=0.
- Minimum latency: ack in cycle N gives instr_valid=1 in cycle N+1.
- Redirect in cycle N:
  - instr_valid=0 from N+1.
  - With no request outstanding, imem_req=1 at redirect_pc in N+1.
- Sustained throughput: one instruction per cycle when ack is returned in the request cycle and hold=0.
- Reset asserted mid-fetch or mid-squash forces all reset values immediately, asynchronously. The pending ack is abandoned.

## Test plan
- Reset release with zero-wait memory that acks whenever imem_req=1 → imem_addr sequence 0x3000, 0x3004, 0x3008. instr_valid rises one cycle after the first ack. op = rdata[31:26].
- hold=1 held for 10 cycles → exactly DEPTH=4 acks occur, then imem_req stays 0. On hold=0, the entries pop in order with PCs 0x3000..0x300C.
- redirect to 0x4000 while a request to 0x3008 is outstanding with 3-cycle ack latency → SQUASH entered. The 0x3008 data is never presented. The next imem_addr is 0x4000, and the first valid pc_out is 0x4000.
- redirect in the same cycle as imem_ack and a pop → FIFO empty next cycle, the acked word is dropped, and the next request address equals redirect_pc.
- redirect to 0xFFFF_FFFC → next fetch addresses 0xFFFF_FFFC then 0x0000_0000.
- rst pulsed while imem_req=1 → all outputs at reset values with no clock edge. Fetch resumes at 0x3000 after release.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch / prefetch stage.
// Issues word fetches over a req/ack handshake and buffers returned words with
// their PCs in a small FIFO. It presents the head entry to decode. Redirects
// flush the FIFO and squash any fetch still in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        hold,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        stall
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_FETCH  = 1'b0,
    ST_SQUASH = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [31:0]     fetch_pc_reg, fetch_pc_next;
  logic            req_reg, req_next;
  logic [31:0]     addr_reg, addr_next;
  logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW:0]     count_reg, count_next;
  logic [AW:0]     count_after;

  logic [31:0]     word_mem [DEPTH];
  logic [31:0]     pc_mem   [DEPTH];

  logic            push;
  logic            pop;
  logic [31:0]     target_pc;

  // Redirect targets are forced to a word boundary; the low bits are ignored.
  assign target_pc = {redirect_pc[31:2], 2'b00};
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // FIFO occupancy events: a redirect suppresses both push and pop because
  // everything buffered (and the word arriving now) is wrong-path.
  always_comb begin
    pop         = (count_reg != '0) && !hold && !redirect;
    push        = (state_reg == ST_FETCH) && req_reg && imem_ack && !redirect;
    count_after = count_reg + (AW+1)'(push) - (AW+1)'(pop);
  end

  // Fetch controller: request issue, back-to-back continuation, redirect and squash.
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    req_next      = req_reg;
    addr_next     = addr_reg;
    rd_ptr_next   = rd_ptr_reg + AW'(pop);
    wr_ptr_next   = wr_ptr_reg + AW'(push);
    count_next    = count_after;

    if (redirect) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end

    case (state_reg)
      ST_FETCH: begin
        if (redirect) begin
          fetch_pc_next = target_pc;
          if (req_reg && !imem_ack) begin
            // Request must stay stable until its ack; remember to drop it.
            state_next = ST_SQUASH;
          end else if (req_reg) begin
            // Word arrives with the redirect: discard it and go idle.
            req_next = 1'b0;
          end else begin
            // Nothing in flight and the FIFO is being emptied: fetch the target now.
            req_next  = 1'b1;
            addr_next = target_pc;
          end
        end else if (req_reg) begin
          if (imem_ack) begin
            fetch_pc_next = addr_reg + 32'd4;
            if (count_after < DEPTH_C) begin
              // Room remains for another word: keep the request up, next address.
              addr_next = addr_reg + 32'd4;
            end else begin
              req_next = 1'b0;
            end
          end
        end else if (count_reg < DEPTH_C) begin
          req_next  = 1'b1;
          addr_next = fetch_pc_reg;
        end
      end

      ST_SQUASH: begin
        if (redirect) begin
          fetch_pc_next = target_pc;
        end
        if (imem_ack) begin
          // Stale word returns: drop it and resume normal issue from fetch_pc.
          req_next   = 1'b0;
          state_next = ST_FETCH;
        end
      end

      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_FETCH;
      fetch_pc_reg <= RESET_PC;
      req_reg      <= 1'b0;
      addr_reg     <= 32'h0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      req_reg      <= req_next;
      addr_reg     <= addr_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
    end
  end

  // FIFO storage; contents need no reset since outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr_reg] <= imem_rdata;
      pc_mem[wr_ptr_reg]   <= addr_reg;
    end
  end

  // Head presentation; zeroed when empty so decode never sees stale data.
  always_comb begin
    instr_valid = (count_reg != '0);
    instr       = instr_valid ? word_mem[rd_ptr_reg] : 32'h0;
    pc_out      = instr_valid ? pc_mem[rd_ptr_reg]   : 32'h0;
    op          = instr[31:26];
    stall       = !instr_valid;
  end

  assign imem_req  = req_reg;
  assign imem_addr = addr_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit.
// The memory model acks with random latency; every accepted word pushes its
// expected {pc, word} into a queue following program order from the last
// reset/redirect. A monitor pops and compares on every consumption.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        hold;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        stall;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .hold(hold),
    .instr(instr), .op(op), .pc_out(pc_out),
    .instr_valid(instr_valid), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  int total = 0;
  int bad   = 0;

  entry_t      exp_q[$];
  logic [31:0] model_pc       = RESET_PC;
  bit          squash_pending = 0;
  bit          busy           = 0;
  int          wait_left      = 0;
  int          q_before       = 0;
  entry_t      head_before;
  int          hold_mode      = 1;
  int          lat_min        = 0;
  int          lat_max        = 0;
  bit          rand_redir     = 0;
  bit          redir_pending  = 0;
  logic [31:0] redir_target   = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"},    32'(imem_req),    32'h0);
    check({tag, "_imem_addr"},   imem_addr,        32'h0);
    check({tag, "_instr"},       instr,            32'h0);
    check({tag, "_op"},          32'(op),          32'h0);
    check({tag, "_pc_out"},      pc_out,           32'h0);
    check({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
    check({tag, "_stall"},       32'(stall),       32'h1);
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_pc       = RESET_PC;
    squash_pending = 0;
    busy           = 0;
    wait_left      = 0;
    q_before       = 0;
  endtask

  // Stimulus driver and memory model; pushes expected entries on accepted acks.
  initial begin
    logic [31:0] tmp;
    imem_ack = 1'b0; imem_rdata = 32'h0; redirect = 1'b0; redirect_pc = 32'h0; hold = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        imem_ack = 1'b0;
        redirect = 1'b0;
        continue;
      end
      q_before = exp_q.size();
      if (q_before != 0) head_before = exp_q[0];

      case (hold_mode)
        0:       hold = 1'b0;
        1:       hold = 1'b1;
        default: hold = ($urandom_range(0, 3) == 0);
      endcase

      imem_ack = 1'b0;
      if (imem_req) begin
        if (!busy) begin
          busy      = 1;
          wait_left = $urandom_range(lat_max, lat_min);
        end
        if (wait_left == 0) begin
          imem_ack = 1'b1;
          busy     = 0;
        end else begin
          wait_left--;
        end
      end
      imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;

      redirect    = 1'b0;
      redirect_pc = $urandom;
      if (redir_pending) begin
        redirect      = 1'b1;
        redirect_pc   = redir_target;
        redir_pending = 0;
      end else if (rand_redir && $urandom_range(0, 24) == 0) begin
        tmp = $urandom;
        if ($urandom_range(0, 3) == 0) tmp[31:5] = '1;
        redirect    = 1'b1;
        redirect_pc = {tmp[31:2], 2'b00};
      end

      if (imem_ack) begin
        if (squash_pending) begin
          squash_pending = 0;
        end else if (!redirect) begin
          check("fetch_addr", imem_addr, model_pc);
          exp_q.push_back('{pc: model_pc, word: mem_word(model_pc)});
          model_pc = model_pc + 32'd4;
        end
      end
      if (redirect) begin
        exp_q.delete();
        model_pc = redirect_pc;
        if (imem_req && !imem_ack) squash_pending = 1;
      end
    end
  end

  // Monitor: compares head presentation and pops the scoreboard on consumption.
  initial begin
    bit     exp_valid;
    entry_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) continue;
      exp_valid = (q_before != 0);
      check("instr_valid", 32'(instr_valid), 32'(exp_valid));
      check("stall",       32'(stall),       32'(!exp_valid));
      if (!exp_valid) begin
        check("instr_idle",  instr,  32'h0);
        check("pc_out_idle", pc_out, 32'h0);
      end else begin
        check("pc_out", pc_out,     head_before.pc);
        check("instr",  instr,      head_before.word);
        check("op",     32'(op),    32'(head_before.word[31:26]));
        if (!hold && !redirect) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL pop_underflow got=empty want=entry");
          end else begin
            e = exp_q.pop_front();
            $display("pop pc=%h instr=%h", e.pc, e.word);
          end
        end
      end
    end
  end

  initial begin
    int  acks;
    bit  found;
    // Reset before any clock edge.
    #1 rst = 1'b1;
    #2 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_clocked");

    // Fill under hold with zero-wait memory.
    hold_mode = 1; lat_min = 0; lat_max = 0; rand_redir = 0;
    model_reset();
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("first_req",  32'(imem_req), 32'h1);
    check("first_addr", imem_addr,     RESET_PC);
    acks = 0;
    repeat (10) begin
      @(negedge clk); #2;
      if (imem_ack) acks++;
    end
    check("hold_acks",     32'(acks),     32'(DEPTH));
    check("hold_req_idle", 32'(imem_req), 32'h0);
    $display("hold phase acks=%0d", acks);

    // Drain in order, then stream.
    hold_mode = 0;
    repeat (12) @(negedge clk);

    // Redirect while a slow request is outstanding.
    lat_min = 2; lat_max = 2;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #2;
      if (imem_req && busy && wait_left >= 1) begin
        found = 1;
        break;
      end
    end
    check("squash_setup", 32'(found), 32'h1);
    redir_target = 32'h0000_4000; redir_pending = 1;
    @(negedge clk);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (instr_valid) begin
        found = 1;
        check("squash_first_pc", pc_out, 32'h0000_4000);
        break;
      end
    end
    check("squash_valid_seen", 32'(found), 32'h1);
    $display("squash phase done");

    // Redirect coinciding with ack and pop.
    lat_min = 0; lat_max = 0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #2;
      if (instr_valid && imem_req) begin
        found = 1;
        break;
      end
    end
    check("ackredir_setup", 32'(found), 32'h1);
    redir_target = 32'h0000_5000; redir_pending = 1;
    @(negedge clk); #2;
    check("ackredir_valid_before", 32'(instr_valid), 32'h1);
    @(posedge clk); #1;
    check("ackredir_flushed", 32'(instr_valid), 32'h0);
    repeat (10) @(negedge clk);
    $display("ack+redirect phase done");

    // Address wrap.
    lat_min = 0; lat_max = 2;
    redir_target = 32'hFFFF_FFFC; redir_pending = 1;
    repeat (20) @(negedge clk);
    $display("wrap phase done");

    // Random traffic.
    hold_mode = 2; lat_min = 0; lat_max = 3; rand_redir = 1;
    repeat (800) @(negedge clk);
    $display("random phase done");

    // Asynchronous reset mid-fetch.
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #3;
      if (imem_req) begin
        found = 1;
        break;
      end
    end
    check("areset_setup", 32'(found), 32'h1);
    rst = 1'b1;
    #1 check_reset_outputs("areset");
    model_reset();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("resume_req",  32'(imem_req), 32'h1);
    check("resume_addr", imem_addr,     RESET_PC);
    repeat (40) @(negedge clk);
    #3;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
